sbox_layer_seq: RTL

- Sequencer directly upstream of the S-box unit: latches the 128-bit column state and feeds it to the S-box unit one column bundle per cycle.
- Collects the substituted bundles into its internal state register and returns the full substituted state with a done pulse.
- Makes the S-box serialization (2**PDSBOX bundles) transparent to the round controller of the Shadow-512 permutation.

---
 rtl/sbox_layer_seq_pkg.sv | 27 ++
 rtl/sbox_layer_seq_if.sv | 29 ++
 rtl/sbox_layer_seq.sv | 102 ++++++++++
 3 files changed

// File: rtl/sbox_layer_seq_pkg.sv
// sbox_layer_seq_pkg: FSM encodings, column geometry and bundle-size helpers
// shared by the S-box sequencer and the S-box unit.
package sbox_layer_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_WB    = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam int COL_W     = 4;
    localparam int N_COLS    = 32;
    localparam int NBITS_DEF = COL_W * N_COLS;

    // Number of bundles the state is split into for a given divider.
    function automatic int nb_of(input int pdsbox);
        return 1 << pdsbox;
    endfunction

    // Bundle width in bits.
    function automatic int sw_of(input int nbits, input int pdsbox);
        return nbits >> pdsbox;
    endfunction

endpackage

// File: rtl/sbox_layer_seq_if.sv
// sbox_layer_seq_if: round-controller / S-box-unit side bus of the S-box sequencer.
// slave = sequencer, master = round datapath driving it.
interface sbox_layer_seq_if
    import sbox_layer_seq_pkg::*;
#(
    parameter int PDSBOX = 0,
    parameter int Nbits  = NBITS_DEF
);
    localparam int SW = sw_of(Nbits, PDSBOX);

    logic             start;
    logic [Nbits-1:0] state_in;
    logic             busy;
    logic             done;
    logic [Nbits-1:0] state_out;
    logic [SW-1:0]    sb_cols;
    logic [SW-1:0]    sb_cols_post;

    modport master (
        output start, state_in, sb_cols_post,
        input  busy, done, state_out, sb_cols
    );

    modport slave (
        input  start, state_in, sb_cols_post,
        output busy, done, state_out, sb_cols
    );

endinterface

// File: rtl/sbox_layer_seq.sv
// sbox_layer_seq: feeds the 128-bit state to the S-box unit one bundle per cycle
// and collects the results in place. Define SBOX_LAYER_PIPE_EN to register the return path.
module sbox_layer_seq
    import sbox_layer_seq_pkg::*;
#(
    parameter int PDSBOX = 0,
    parameter int Nbits  = NBITS_DEF
) (
    input  logic              clk,
    input  logic              rst,
    sbox_layer_seq_if.slave   bus
);
    localparam int NB = nb_of(PDSBOX);
    localparam int SW = sw_of(Nbits, PDSBOX);
    localparam int KW = (PDSBOX > 0) ? PDSBOX : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NB - 1);
`ifdef SBOX_LAYER_PIPE_EN
    localparam bit PIPE = 1'b1;
`else
    localparam bit PIPE = 1'b0;
`endif

    state_t           state;
    logic [Nbits-1:0] state_q;
    logic [KW-1:0]    k;
    logic             busy_q;
    logic             done_q;

    assign bus.sb_cols   = state_q[int'(k)*SW +: SW];
    assign bus.state_out = state_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

`ifdef SBOX_LAYER_PIPE_EN
    logic [SW-1:0] pipe_data;
    logic [KW-1:0] pipe_idx;
    logic          pipe_vld;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            state_q <= '0;
            k       <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SBOX_LAYER_PIPE_EN
            pipe_data <= '0;
            pipe_idx  <= '0;
            pipe_vld  <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: if (bus.start) begin
                    state_q <= bus.state_in;
                    k       <= '0;
                    busy_q  <= 1'b1;
                    state   <= (PIPE || NB > 1) ? S_RUN : S_WB;
                end
                S_RUN: begin
`ifndef SBOX_LAYER_PIPE_EN
                    state_q[int'(k)*SW +: SW] <= bus.sb_cols_post;
`endif
                    if (k == K_LAST) begin
                        k      <= '0;
                        state  <= PIPE ? S_DRAIN : S_DONE;
                        busy_q <= PIPE;
                        done_q <= !PIPE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                S_WB: begin
                    state_q[int'(k)*SW +: SW] <= bus.sb_cols_post;
                    state  <= S_DONE;
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
                S_DRAIN: begin
                    state  <= S_DONE;
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    done_q <= 1'b0;
                    k      <= '0;
                end
                default: state <= S_IDLE;
            endcase
`ifdef SBOX_LAYER_PIPE_EN
            // Bundle k is written one cycle after issue; k+1 still reads untouched data.
            pipe_vld  <= (state == S_RUN);
            pipe_data <= bus.sb_cols_post;
            pipe_idx  <= k;
            if (pipe_vld)
                state_q[int'(pipe_idx)*SW +: SW] <= pipe_data;
`endif
        end
    end

endmodule
